// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial deserializer.
// The PARITY state is only entered in builds that define DESER_PARITY_EN.
package deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } deser_state_t;

    localparam int DESER_DEFAULT_WIDTH = 4;

    // Bit-count register width: must be able to hold the value WIDTH.
    function automatic int deser_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for completed words.
// A load while full and not being drained is dropped and flagged by a one-cycle overrun pulse.
module deser_out_buf #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic [PW-1:0] din,
    input  logic          ready,
    output logic [PW-1:0] q,
    output logic          valid,
    output logic          overrun
);

    logic can_load;

    assign can_load = !valid || ready;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (can_load) begin
                    q     <= din;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver: frame-marked bit stream to WIDTH-bit words via a one-entry output buffer.
// Optional even-parity bit after the data bits is enabled by defining DESER_PARITY_EN.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             busy
`ifdef DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = deser_cnt_width(WIDTH);
`ifdef DESER_PARITY_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    deser_state_t     state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n, sh;
    logic             order, order_n;
    logic             word_done;
    logic [PW-1:0]    payload;
    logic [PW-1:0]    buf_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sr    <= '0;
            order <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            order <= order_n;
        end
    end

    // LSB-first enters at the top and walks right; MSB-first enters at the bottom and walks left.
    assign sh = order ? {sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        order_n   = order;
        word_done = 1'b0;
        payload   = '0;

        if (sin_valid) begin
            if (frame) begin
                // A frame bit always starts a fresh word, discarding any partial one.
                order_n = lsb_first;
                cnt_n   = CW'(1);
                sr_n    = lsb_first ? {sin, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, sin};
                state_n = ST_SHIFT;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_SHIFT: begin
                        sr_n  = sh;
                        cnt_n = cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n   = ST_IDLE;
                            cnt_n     = '0;
                            word_done = 1'b1;
                            payload   = sh;
`endif
                        end
                    end
`ifdef DESER_PARITY_EN
                    ST_PARITY: begin
                        state_n   = ST_IDLE;
                        cnt_n     = '0;
                        word_done = 1'b1;
                        payload   = {(^sr) ^ sin, sr};
                    end
`endif
                    default: begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);

    deser_out_buf #(
        .PW (PW)
    ) u_out_buf (
        .clk     (clk),
        .clear   (clear),
        .load    (word_done),
        .din     (payload),
        .ready   (dout_ready),
        .q       (buf_q),
        .valid   (dout_valid),
        .overrun (overrun)
    );

`ifdef DESER_PARITY_EN
    assign dout       = buf_q[WIDTH-1:0];
    assign parity_err = buf_q[WIDTH];
`else
    assign dout = buf_q;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer with WIDTH=4.
// The parity scenario runs only when DESER_PARITY_EN is defined.
module tb_serial_deserializer;

    logic       clk;
    logic       clear;
    logic       sin;
    logic       sin_valid;
    logic       frame;
    logic       lsb_first;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overrun;
    logic       busy;
`ifdef DESER_PARITY_EN
    logic       parity_err;
`endif

    int pass_cnt = 0;
    int total    = 0;

    serial_deserializer #(
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .frame      (frame),
        .lsb_first  (lsb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .busy       (busy)
`ifdef DESER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bit for exactly one rising edge, then return to idle inputs.
    task automatic bit_in(input logic b, input logic f);
        sin       = b;
        frame     = f;
        sin_valid = 1'b1;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        frame     = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({dout, dout_valid, overrun, busy} !== 7'b0) $display("FAIL reset_init got dout=%b v=%b ovr=%b busy=%b exp all 0", dout, dout_valid, overrun, busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        clear = 1'b1;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) $display("FAIL reset_busy_mid got %b exp 1", busy);
        else pass_cnt++;
        #2;
        clear = 1'b0;
        #1;
        total++;
        if ({dout, dout_valid, overrun, busy} !== 7'b0) $display("FAIL reset_async got dout=%b v=%b ovr=%b busy=%b exp all 0", dout, dout_valid, overrun, busy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        clear = 1'b1;
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_ignore_busy got %b exp 0", busy);
        else pass_cnt++;
        idle(2);
        total++;
        if (dout_valid !== 1'b0) $display("FAIL reset_ignore_valid got %b exp 0", dout_valid);
        else pass_cnt++;
    endtask

    task automatic test_lsb_first();
        lsb_first  = 1'b1;
        dout_ready = 1'b0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (dout_valid !== 1'b0 || busy !== 1'b1) $display("FAIL lsb_before_last got v=%b busy=%b exp v=0 busy=1", dout_valid, busy);
        else pass_cnt++;
        bit_in(1'b1, 1'b0);
        total++;
        if (dout_valid !== 1'b1 || dout !== 4'b1101 || busy !== 1'b0) $display("FAIL lsb_word got v=%b dout=%b busy=%b exp v=1 dout=1101 busy=0", dout_valid, dout, busy);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            total++;
            if (dout_valid !== 1'b1 || dout !== 4'b1101) $display("FAIL lsb_hold[%0d] got v=%b dout=%b exp v=1 dout=1101", i, dout_valid, dout);
            else pass_cnt++;
        end
        drain();
        total++;
        if (dout_valid !== 1'b0) $display("FAIL lsb_consumed got %b exp 0", dout_valid);
        else pass_cnt++;
    endtask

    task automatic test_msb_first();
        lsb_first = 1'b0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (dout_valid !== 1'b1 || dout !== 4'b1011) $display("FAIL msb_word got v=%b dout=%b exp v=1 dout=1011", dout_valid, dout);
        else pass_cnt++;
        drain();
        bit_in(1'b1, 1'b1);
        idle(1);
        bit_in(1'b0, 1'b0);
        idle(2);
        total++;
        if (busy !== 1'b1 || dout_valid !== 1'b0) $display("FAIL msb_gap_busy got busy=%b v=%b exp busy=1 v=0", busy, dout_valid);
        else pass_cnt++;
        bit_in(1'b1, 1'b0);
        idle(2);
        bit_in(1'b1, 1'b0);
        total++;
        if (dout_valid !== 1'b1 || dout !== 4'b1011) $display("FAIL msb_gap_word got v=%b dout=%b exp v=1 dout=1011", dout_valid, dout);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_overrun();
        lsb_first  = 1'b1;
        dout_ready = 1'b0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        total++;
        if (dout !== 4'b0011 || overrun !== 1'b0) $display("FAIL ovr_first got dout=%b ovr=%b exp dout=0011 ovr=0", dout, overrun);
        else pass_cnt++;
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (overrun !== 1'b1 || dout !== 4'b0011 || dout_valid !== 1'b1) $display("FAIL ovr_drop got ovr=%b dout=%b v=%b exp ovr=1 dout=0011 v=1", overrun, dout, dout_valid);
        else pass_cnt++;
        idle(1);
        total++;
        if (overrun !== 1'b0 || dout !== 4'b0011) $display("FAIL ovr_pulse_end got ovr=%b dout=%b exp ovr=0 dout=0011", overrun, dout);
        else pass_cnt++;
        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        dout_ready = 1'b1;
        bit_in(1'b0, 1'b0);
        dout_ready = 1'b0;
        total++;
        if (overrun !== 1'b0 || dout !== 4'b0110 || dout_valid !== 1'b1) $display("FAIL ovr_ready_load got ovr=%b dout=%b v=%b exp ovr=0 dout=0110 v=1", overrun, dout, dout_valid);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_resync();
        lsb_first = 1'b1;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b1);
        total++;
        if (busy !== 1'b1 || dout_valid !== 1'b0 || overrun !== 1'b0) $display("FAIL resync_restart got busy=%b v=%b ovr=%b exp 1 0 0", busy, dout_valid, overrun);
        else pass_cnt++;
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (dout_valid !== 1'b0) $display("FAIL resync_not_early got v=%b exp 0", dout_valid);
        else pass_cnt++;
        bit_in(1'b0, 1'b0);
        total++;
        if (dout !== 4'b0110 || dout_valid !== 1'b1 || overrun !== 1'b0) $display("FAIL resync_word got dout=%b v=%b ovr=%b exp dout=0110 v=1 ovr=0", dout, dout_valid, overrun);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_back_to_back();
        lsb_first  = 1'b1;
        dout_ready = 1'b1;
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (dout !== 4'b1100 || dout_valid !== 1'b1) $display("FAIL b2b_first got dout=%b v=%b exp dout=1100 v=1", dout, dout_valid);
        else pass_cnt++;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (dout !== 4'b1001 || dout_valid !== 1'b1 || overrun !== 1'b0) $display("FAIL b2b_second got dout=%b v=%b ovr=%b exp dout=1001 v=1 ovr=0", dout, dout_valid, overrun);
        else pass_cnt++;
        idle(1);
        dout_ready = 1'b0;
        total++;
        if (dout_valid !== 1'b0) $display("FAIL b2b_drained got v=%b exp 0", dout_valid);
        else pass_cnt++;
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        lsb_first  = 1'b1;
        dout_ready = 1'b0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        total++;
        if (dout_valid !== 1'b0 || busy !== 1'b1) $display("FAIL par_wait got v=%b busy=%b exp v=0 busy=1", dout_valid, busy);
        else pass_cnt++;
        bit_in(1'b1, 1'b0);
        total++;
        if (dout !== 4'b1101 || parity_err !== 1'b0 || dout_valid !== 1'b1) $display("FAIL par_good got dout=%b perr=%b v=%b exp 1101 0 1", dout, parity_err, dout_valid);
        else pass_cnt++;
        drain();
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        total++;
        if (dout !== 4'b1101 || parity_err !== 1'b1 || dout_valid !== 1'b1) $display("FAIL par_bad got dout=%b perr=%b v=%b exp 1101 1 1", dout, parity_err, dout_valid);
        else pass_cnt++;
        drain();
    endtask
`endif

    initial begin
        clear      = 1'b0;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        frame      = 1'b0;
        lsb_first  = 1'b1;
        dout_ready = 1'b0;
        test_reset();
`ifdef DESER_PARITY_EN
        test_parity();
`else
        test_lsb_first();
        test_msb_first();
        test_overrun();
        test_resync();
        test_back_to_back();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
